game_flow_controller: RTL and testbench

- Frame-synchronous sequencer that owns all game-level state consumed by the VGA renderer: game_state, level, lava_wall_x, lava_height.
- Advances the hazards (lava wall, rising lava band) on a frame cadence.
- Detects death, goal and win from physics flags, and runs restart and level-load sequencing.
- Sits between the player-physics block and the pixel renderer. All output changes are aligned to vblank, so no frame shows a half-updated scene.

---
 rtl/game_flow_controller_pkg.sv | 26 ++
 rtl/game_flow_controller_if.sv | 26 ++
 rtl/game_flow_controller_prescaler.sv | 45 ++++
 rtl/game_flow_controller.sv | 162 ++++++++++++++++
 tb/tb_game_flow_controller.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared game-level types and screen geometry for the flow controller and the renderer.
package game_pkg;

    typedef enum logic [2:0] {
        S_RUNNING   = 3'd0,
        S_GAME_OVER = 3'd1,
        S_WIN       = 3'd2,
        S_LOAD      = 3'd3
    } game_state_e;

    typedef logic [1:0] level_t;

    localparam int SCREEN_WIDTH    = 640;
    localparam int SCREEN_HEIGHT   = 480;
    localparam int LAVA_WALL_WIDTH = 10;

    // Adds inc to a and clamps the result to cap without losing the carry.
    function automatic logic [9:0] sat_add(input logic [9:0] a,
                                           input logic [9:0] inc,
                                           input logic [9:0] cap);
        logic [10:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return (sum > {1'b0, cap}) ? cap : sum[9:0];
    endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Bundle between the frame/physics side and the game flow controller.
interface game_flow_controller_if;
    import game_pkg::*;

    logic       frame_tick;
    logic       start_btn;
    logic       player_hit;
    logic       player_at_goal;
    logic [9:0] player_x;
    logic [2:0] game_state;
    level_t     level;
    logic [9:0] lava_wall_x;
    logic [9:0] lava_height;
    logic       level_load;

    modport master (
        output frame_tick, start_btn, player_hit, player_at_goal, player_x,
        input  game_state, level, lava_wall_x, lava_height, level_load
    );

    modport slave (
        input  frame_tick, start_btn, player_hit, player_at_goal, player_x,
        output game_state, level, lava_wall_x, lava_height, level_load
    );

endinterface

// File: rtl/game_flow_controller_prescaler.sv
// Frame divider: counts enabled frame ticks and pulses step on every DIV-th one.
module frame_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic step_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    // Step is independent of clear so the caller can derive clear from it.
    assign step_o = frame_tick_i & enable_i & wrap;

    always_comb begin
        // NOTE: assign the default first so no branch leaves cnt_d unassigned and infers a latch.
        cnt_d = cnt_q;
        if (frame_tick_i) begin
            if (clear_i) begin
                cnt_d = '0;
            end else if (enable_i) begin
                cnt_d = wrap ? '0 : cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Frame-synchronous game sequencer: advances hazards, detects death/goal/win and
// sequences level loads; every visible output changes only on a frame tick.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int LAVA_WALL_START = 0,
    parameter int LAVA_WALL_STEP  = 1,
    parameter int LAVA_WALL_DIV   = 4,
    parameter int LAVA_RISE_DIV   = 8,
    parameter int LAVA_HEIGHT_MAX = 200,
    parameter int END_HOLD_FRAMES = 120,
    parameter int NUM_LEVELS      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    game_flow_controller_if.slave gf
);

    localparam int                HOLD_W     = $clog2(END_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(END_HOLD_FRAMES);
    localparam logic [9:0]        WALL_START = 10'(LAVA_WALL_START);
    localparam logic [9:0]        WALL_STEP  = 10'(LAVA_WALL_STEP);
    localparam logic [9:0]        WALL_MAX   = 10'(SCREEN_WIDTH - 1);
    // A band taller than the screen has no visible meaning.
    localparam int                HEIGHT_CAP_INT = (LAVA_HEIGHT_MAX < SCREEN_HEIGHT) ?
                                                   LAVA_HEIGHT_MAX : SCREEN_HEIGHT;
    localparam logic [9:0]        HEIGHT_CAP = 10'(HEIGHT_CAP_INT);
    localparam level_t            LAST_LEVEL = level_t'(NUM_LEVELS - 1);

    game_state_e       state_q, state_d;
    level_t            level_q, level_d;
    logic [9:0]        wall_x_q, wall_x_d;
    logic [9:0]        height_q, height_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              start_pending_q, start_pending_d;
    logic              level_load_q, level_load_d;

    logic       running, end_state, enter_load;
    logic       wall_step, rise_step, wall_hits_player, death;
    logic [9:0] wall_next, height_next;

    assign running   = (state_q == S_RUNNING);
    assign end_state = (state_q == S_GAME_OVER) || (state_q == S_WIN);

    frame_prescaler #(.DIV(LAVA_WALL_DIV)) u_wall_div (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick_i (gf.frame_tick),
        .clear_i      (enter_load),
        .enable_i     (running),
        .step_o       (wall_step)
    );

    frame_prescaler #(.DIV(LAVA_RISE_DIV)) u_rise_div (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick_i (gf.frame_tick),
        .clear_i      (enter_load),
        .enable_i     (running),
        .step_o       (rise_step)
    );

    // The wall only moves on the first level; the band rises on every level.
    assign wall_next   = (wall_step && level_q == '0) ?
                         sat_add(wall_x_q, WALL_STEP, WALL_MAX) : wall_x_q;
    assign height_next = rise_step ? sat_add(height_q, 10'd1, HEIGHT_CAP) : height_q;

    // Death is judged against the wall position this frame will display.
    assign wall_hits_player = (level_q == '0) &&
                              (({1'b0, wall_next} + 11'(LAVA_WALL_WIDTH)) > {1'b0, gf.player_x});
    assign death            = gf.player_hit || wall_hits_player;

    always_comb begin
        state_d         = state_q;
        level_d         = level_q;
        wall_x_d        = wall_x_q;
        height_d        = height_q;
        hold_d          = hold_q;
        start_pending_d = start_pending_q | (gf.start_btn & end_state);
        level_load_d    = 1'b0;
        enter_load      = 1'b0;

        if (gf.frame_tick) begin
            unique case (state_q)
                S_LOAD: begin
                    state_d         = S_RUNNING;
                    start_pending_d = 1'b0;
                end
                S_RUNNING: begin
                    wall_x_d = wall_next;
                    height_d = height_next;
                    if (death) begin
                        state_d         = S_GAME_OVER;
                        start_pending_d = 1'b0;
                    end else if (gf.player_at_goal) begin
                        if (level_q == LAST_LEVEL) begin
                            state_d         = S_WIN;
                            start_pending_d = 1'b0;
                        end else begin
                            level_d    = level_q + level_t'(1);
                            enter_load = 1'b1;
                        end
                    end
                end
                S_GAME_OVER, S_WIN: begin
                    if (hold_q == HOLD_MAX && start_pending_q) begin
                        enter_load = 1'b1;
                        if (state_q == S_WIN) begin
                            level_d = '0;
                        end
                    end else begin
                        // A press only survives if it arrives after the hold expired.
                        if (hold_q < HOLD_MAX) begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                        start_pending_d = gf.start_btn;
                    end
                end
                default: begin
                    enter_load = 1'b1;
                    level_d    = '0;
                end
            endcase

            if (enter_load) begin
                state_d         = S_LOAD;
                wall_x_d        = WALL_START;
                height_d        = '0;
                hold_d          = '0;
                start_pending_d = 1'b0;
                level_load_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_LOAD;
            level_q         <= '0;
            wall_x_q        <= WALL_START;
            height_q        <= '0;
            hold_q          <= '0;
            start_pending_q <= 1'b0;
            level_load_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            level_q         <= level_d;
            wall_x_q        <= wall_x_d;
            height_q        <= height_d;
            hold_q          <= hold_d;
            start_pending_q <= start_pending_d;
            level_load_q    <= level_load_d;
        end
    end

    assign gf.game_state  = state_q;
    assign gf.level       = level_q;
    assign gf.lava_wall_x = wall_x_q;
    assign gf.lava_height = height_q;
    assign gf.level_load  = level_load_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: vector table, directed corner sequences and a
// randomized run against a frame-count based reference model.
module tb_game_flow_controller;

    localparam int WALL_START = 0;
    localparam int WALL_STEP  = 1;
    localparam int WALL_DIV   = 4;
    localparam int RISE_DIV   = 8;
    localparam int HEIGHT_MAX = 200;
    localparam int HOLD       = 120;
    localparam int LEVELS     = 2;
    localparam int WALL_LIMIT = 639;

    localparam int ST_RUN  = 0;
    localparam int ST_GO   = 1;
    localparam int ST_WIN  = 2;
    localparam int ST_LOAD = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    game_flow_controller_if bus ();

    game_flow_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gf    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         n;
        logic       hit;
        logic       goal;
        logic [9:0] px;
        logic       btn;
        int         st;
        int         lv;
        int         wall;
        int         ht;
        int         ld;
    } vec_t;

    vec_t vecs [11];

    // Reference model: hazards derive from the number of running frames since load.
    int m_state, m_level, m_run, m_hold;
    bit m_press, m_load;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int lv,
                             input int wall, input int ht, input int ld);
        check({tag, " state"},       int'(bus.game_state),  st);
        check({tag, " level"},       int'(bus.level),       lv);
        check({tag, " lava_wall_x"}, int'(bus.lava_wall_x), wall);
        check({tag, " lava_height"}, int'(bus.lava_height), ht);
        check({tag, " level_load"},  int'(bus.level_load),  ld);
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.frame_tick     = 1'b0;
        bus.start_btn      = 1'b0;
        bus.player_hit     = 1'b0;
        bus.player_at_goal = 1'b0;
        bus.player_x       = 10'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One idle cycle (optional press) followed by one frame_tick cycle.
    task automatic frame(input logic hit, input logic goal, input logic [9:0] px,
                         input logic btn_idle, input logic btn_tick);
        bus.start_btn = btn_idle;
        @(posedge clk);
        #1;
        bus.start_btn      = btn_tick;
        bus.player_hit     = hit;
        bus.player_at_goal = goal;
        bus.player_x       = px;
        bus.frame_tick     = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick     = 1'b0;
        bus.start_btn      = 1'b0;
        bus.player_hit     = 1'b0;
        bus.player_at_goal = 1'b0;
    endtask

    function automatic int m_wall();
        int w;
        if (m_level != 0) return WALL_START;
        w = WALL_START + (m_run / WALL_DIV) * WALL_STEP;
        return (w > WALL_LIMIT) ? WALL_LIMIT : w;
    endfunction

    function automatic int m_height();
        int h;
        h = m_run / RISE_DIV;
        return (h > HEIGHT_MAX) ? HEIGHT_MAX : h;
    endfunction

    task automatic m_reset();
        m_state = ST_LOAD;
        m_level = 0;
        m_run   = 0;
        m_hold  = 0;
        m_press = 1'b0;
        m_load  = 1'b0;
    endtask

    task automatic m_enter_load();
        m_state = ST_LOAD;
        m_run   = 0;
        m_hold  = 0;
        m_press = 1'b0;
        m_load  = 1'b1;
    endtask

    task automatic m_idle(input bit btn);
        if (btn && (m_state == ST_GO || m_state == ST_WIN)) m_press = 1'b1;
    endtask

    task automatic m_tick(input bit hit, input bit goal, input int px, input bit btn);
        m_load = 1'b0;
        case (m_state)
            ST_LOAD: m_state = ST_RUN;
            ST_RUN: begin
                m_run++;
                if (hit || (m_level == 0 && m_wall() + 10 > px)) begin
                    m_state = ST_GO;
                end else if (goal) begin
                    if (m_level == LEVELS - 1) begin
                        m_state = ST_WIN;
                    end else begin
                        m_level++;
                        m_enter_load();
                    end
                end
            end
            default: begin
                if (m_hold == HOLD && m_press) begin
                    if (m_state == ST_WIN) m_level = 0;
                    m_enter_load();
                end else begin
                    if (m_hold < HOLD) m_hold++;
                    m_press = btn;
                end
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        check_all("reset", ST_LOAD, 0, 0, 0, 0);

        //            n    hit   goal  px       btn   state    lv wall ht ld
        vecs[0]  = '{1,   1'b0, 1'b0, 10'd500, 1'b0, ST_RUN,  0, 0,   0, 0};
        vecs[1]  = '{16,  1'b0, 1'b0, 10'd500, 1'b0, ST_RUN,  0, 4,   2, 0};
        vecs[2]  = '{1,   1'b1, 1'b1, 10'd500, 1'b0, ST_GO,   0, 4,   2, 0};
        vecs[3]  = '{120, 1'b0, 1'b0, 10'd500, 1'b0, ST_GO,   0, 4,   2, 0};
        vecs[4]  = '{1,   1'b0, 1'b0, 10'd500, 1'b1, ST_GO,   0, 4,   2, 0};
        vecs[5]  = '{1,   1'b0, 1'b0, 10'd500, 1'b0, ST_LOAD, 0, 0,   0, 1};
        vecs[6]  = '{1,   1'b0, 1'b0, 10'd500, 1'b0, ST_RUN,  0, 0,   0, 0};
        vecs[7]  = '{1,   1'b0, 1'b1, 10'd500, 1'b0, ST_LOAD, 1, 0,   0, 1};
        vecs[8]  = '{1,   1'b0, 1'b0, 10'd500, 1'b0, ST_RUN,  1, 0,   0, 0};
        vecs[9]  = '{16,  1'b0, 1'b0, 10'd5,   1'b0, ST_RUN,  1, 0,   2, 0};
        vecs[10] = '{1,   1'b0, 1'b1, 10'd5,   1'b0, ST_WIN,  1, 0,   2, 0};

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                frame(vecs[i].hit, vecs[i].goal, vecs[i].px, 1'b0, vecs[i].btn);
            end
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv,
                      vecs[i].wall, vecs[i].ht, vecs[i].ld);
        end

        // WIN: a press at hold frame 50 is dropped; a press after expiry restarts at level 0.
        repeat (49) frame(1'b0, 1'b0, 10'd5, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 10'd5, 1'b1, 1'b0);
        check_all("win early press", ST_WIN, 1, 0, 2, 0);
        repeat (70) frame(1'b0, 1'b0, 10'd5, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 10'd5, 1'b0, 1'b0);
        check_all("win press discarded", ST_WIN, 1, 0, 2, 0);
        frame(1'b0, 1'b0, 10'd5, 1'b1, 1'b0);
        check_all("win restart", ST_LOAD, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        check("win level_load width", int'(bus.level_load), 0);
        frame(1'b0, 1'b0, 10'd500, 1'b0, 1'b0);
        check_all("win restart run", ST_RUN, 0, 0, 0, 0);

        // Wall catches a player at x=100 when it reaches 91.
        repeat (363) frame(1'b0, 1'b0, 10'd100, 1'b0, 1'b0);
        check_all("catchup pre", ST_RUN, 0, 90, 45, 0);
        frame(1'b0, 1'b0, 10'd100, 1'b0, 1'b0);
        check_all("catchup hit", ST_GO, 0, 91, 45, 0);
        repeat (10) frame(1'b0, 1'b0, 10'd100, 1'b0, 1'b0);
        check_all("catchup frozen", ST_GO, 0, 91, 45, 0);
        repeat (109) frame(1'b0, 1'b0, 10'd100, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 10'd100, 1'b1, 1'b0);
        check_all("go last hold press", ST_GO, 0, 91, 45, 0);
        frame(1'b0, 1'b0, 10'd100, 1'b0, 1'b0);
        check_all("go press discarded", ST_GO, 0, 91, 45, 0);
        frame(1'b0, 1'b0, 10'd100, 1'b1, 1'b0);
        check_all("go restart", ST_LOAD, 0, 0, 0, 1);
        frame(1'b0, 1'b0, 10'd1023, 1'b0, 1'b0);
        check_all("go restart run", ST_RUN, 0, 0, 0, 0);

        // Saturation of the band at 200 and the wall at 639.
        repeat (1599) frame(1'b0, 1'b0, 10'd1023, 1'b0, 1'b0);
        check_all("sat pre", ST_RUN, 0, 399, 199, 0);
        frame(1'b0, 1'b0, 10'd1023, 1'b0, 1'b0);
        check_all("sat height", ST_RUN, 0, 400, 200, 0);
        repeat (8) frame(1'b0, 1'b0, 10'd1023, 1'b0, 1'b0);
        check_all("sat height hold", ST_RUN, 0, 402, 200, 0);
        repeat (948) frame(1'b0, 1'b0, 10'd1023, 1'b0, 1'b0);
        check_all("sat wall", ST_RUN, 0, 639, 200, 0);
        repeat (4) frame(1'b0, 1'b0, 10'd1023, 1'b0, 1'b0);
        check_all("sat wall hold", ST_RUN, 0, 639, 200, 0);

        // Reset asserted mid-cycle takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_all("async reset", ST_LOAD, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("after reset", ST_LOAD, 0, 0, 0, 0);

        // Randomized frames against the reference model.
        do_reset();
        m_reset();
        for (int f = 0; f < 3000; f++) begin
            logic       hit, goal, bi, bt;
            logic [9:0] px;
            hit  = ($urandom_range(0, 49) == 0);
            goal = ($urandom_range(0, 29) == 0);
            px   = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 255))
                                               : 10'($urandom_range(0, 1023));
            bi   = ($urandom_range(0, 3) == 0);
            bt   = ($urandom_range(0, 7) == 0);
            m_idle(bi);
            m_tick(hit, goal, int'(px), bt);
            frame(hit, goal, px, bi, bt);
            check_all($sformatf("rand%0d", f), m_state, m_level, m_wall(), m_height(),
                      int'(m_load));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
